fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Single-outstanding instruction-fetch controller that owns the program counter and sequences instruction-memory requests for the RISC-V core. It arbitrates between sequential fetch, branch/JAL redirects (target = br_pc + ImmOp) and JALR redirects (target = ALUresult). It honours pipeline stalls and discards in-flight responses made stale by a redirect. It sits between the decode/execute control (PCsrc, stall) and the instruction memory port.

## Interface
- DATA_WIDTH, 32, width of PC, immediates, addresses and instruction words
- RESET_PC, 0, first fetch address after reset
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- PCsrc  input  2  redirect select: 00 none, 01 br_pc+ImmOp (B-type taken/JAL), 10 ALUresult (JALR), 11 treated as 00
- br_pc  input  DATA_WIDTH  PC of the redirecting instruction
- ImmOp  input  DATA_WIDTH  sign-extended branch/JAL offset
- ALUresult  input  DATA_WIDTH  JALR target
- stall  input  1  decode cannot accept an instruction this cycle
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_addr  output  DATA_WIDTH  fetch address
- imem_rsp_valid  input  1  response data valid (one per accepted request, ≥1 cycle after acceptance)
- imem_rdata  input  DATA_WIDTH  instruction word
- instr_valid  output  1  instr/instr_pc valid to decode
- instr  output  DATA_WIDTH  fetched instruction
- instr_pc  output  DATA_WIDTH  address of instr
- pcplus4  output  DATA_WIDTH  instr_pc + 4, modulo 2^DATA_WIDTH
- misalign  output  1  misaligned redirect trap (only with FETCH_MISALIGN_TRAP_EN)

## Operation
- States: REQ (drive request), WAIT (accepted, awaiting response), HOLD (instruction presented, decode stalled), TRAP (macro only).
- Internal registers: pc (next fetch address), stale flag, instruction buffer (instr, instr_pc, instr_valid).
- Redirect = PCsrc ∈ {01,10}. Target = (br_pc + ImmOp) or ALUresult, truncated to DATA_WIDTH. A redirect overrides sequential fetch in every state. It is sampled in any cycle and loads pc <= target.
- REQ: imem_req_valid=1, imem_addr=pc.
  - On accept (valid&&ready) → WAIT, pc <= pc+4.
  - If a redirect coincides with accept, the accepted request is marked stale, pc <= target, and the state still goes to WAIT.
  - A redirect while not accepted retargets imem_addr next cycle. This is the only permitted address change of an unaccepted request.
- WAIT: imem_req_valid=0.
  - On imem_rsp_valid with stale=0: load buffer, instr_valid=1; → REQ if stall=0, else HOLD.
  - On imem_rsp_valid with stale=1: drop data, clear stale, → REQ.
  - A redirect in WAIT sets stale=1. A redirect in the same cycle as the response drops that response.
- HOLD: buffer held stable, imem_req_valid=0.
  - → REQ when stall=0.
  - A redirect in HOLD clears instr_valid next cycle and → REQ at target.
- Buffer: instr_valid drops the cycle after consumption (instr_valid&&!stall) unless a new response loads it. Any redirect clears instr_valid next cycle, because the buffered instruction is younger than the redirecting one.

## Timing
- Reset (async assert, sync-released): state=REQ, pc=RESET_PC, stale=0, instr_valid=0, instr=0, instr_pc=0, pcplus4=4, imem_req_valid=0 in reset, misalign=0.
- First request: imem_req_valid=1 in the first clock cycle after rst_n rises.
- Latency: request accept → instr_valid in the cycle after imem_rsp_valid (registered). Redirect → imem_addr=target in the next cycle.
- Zero-wait memory (ready=1, response 1 cycle after accept) sustains one instruction per 2 cycles (single outstanding).
- PC wraps modulo 2^DATA_WIDTH: pc 0xFFFFFFFC + 4 = 0x00000000.
- Reset mid-operation: all state is lost immediately, and a pending response after reset release is ignored (stale=1 forced if rst released in WAIT is not needed; state restarts in REQ).

## Configuration
- FETCH_MISALIGN_TRAP_EN defined: a redirect target with bits[1:0]≠0 enters TRAP.
  - TRAP: misalign=1, instr_pc=target, instr_valid=0, no requests issued.
  - TRAP persists until a subsequent aligned redirect, then → REQ.
- FETCH_MISALIGN_TRAP_EN undefined: target bits[1:0] are forced to 00, misalign is tied 0, and TRAP does not exist.

## Test plan
- Reset, RESET_PC=0x100, ready=1, 1-cycle response -> addresses 0x100, 0x104, 0x108; instr_pc/pcplus4 track (0x100/0x104, ...).
- Redirect PCsrc=01, br_pc=0x200, ImmOp=0xFFFFFFF0 during WAIT -> in-flight response dropped; next imem_addr=0x1F0; no instr_valid for the stale word.
- PCsrc=10, ALUresult=0x3000 in same cycle as accept of 0x108 -> 0x108 response dropped; next request 0x3000.
- stall=1 for 3 cycles with instr_valid=1 -> instr/instr_pc stable, no new request; stall=0 -> next request issued the following cycle.
- pc=0xFFFFFFFC sequential -> next imem_addr=0x00000000, pcplus4=0x00000000.
- With FETCH_MISALIGN_TRAP_EN, JALR ALUresult=0x402 -> misalign=1, instr_pc=0x402, no requests. Then PCsrc=10, ALUresult=0x400 -> misalign=0, fetch 0x400. Without the macro -> fetch 0x400 directly.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/response port of the fetch sequencer.
// master = fetch side, slave = memory side.
interface fetch_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [DATA_WIDTH-1:0] imem_addr;
    logic                  imem_rsp_valid;
    logic [DATA_WIDTH-1:0] imem_rdata;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Single-outstanding instruction fetch controller with branch/JAL/JALR redirect and stale-response discard.
// Optional misaligned-redirect trap: define FETCH_MISALIGN_TRAP_EN.
module fetch_sequencer #(
    parameter int                  DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            PCsrc,
    input  logic [DATA_WIDTH-1:0] br_pc,
    input  logic [DATA_WIDTH-1:0] ImmOp,
    input  logic [DATA_WIDTH-1:0] ALUresult,
    input  logic                  stall,
    fetch_sequencer_if.master     imem,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instr_pc,
    output logic [DATA_WIDTH-1:0] pcplus4,
    output logic                  misalign
);

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_TRAP} state_t;
`else
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
`endif

    state_t                state_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] fetch_addr_q;
    logic                  stale_q;
    logic                  req_valid_q;
    logic                  instr_valid_q;
    logic [DATA_WIDTH-1:0] instr_q;
    logic [DATA_WIDTH-1:0] instr_pc_q;

    logic                  redirect;
    logic [DATA_WIDTH-1:0] target_raw;
    logic [DATA_WIDTH-1:0] target;
    logic                  accept;

    always_comb begin
        redirect   = (PCsrc == 2'b01) || (PCsrc == 2'b10);
        target_raw = (PCsrc == 2'b10) ? ALUresult : (br_pc + ImmOp);
`ifdef FETCH_MISALIGN_TRAP_EN
        target     = target_raw;
`else
        target     = {target_raw[DATA_WIDTH-1:2], 2'b00};
`endif
    end

    // Hold off a new request while an unconsumed instruction sits in the buffer,
    // so a fresh response can never overwrite it.
    assign imem.imem_req_valid = req_valid_q && !(instr_valid_q && stall);
    assign imem.imem_addr      = pc_q;
    assign accept              = imem.imem_req_valid && imem.imem_req_ready;

    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign pcplus4     = instr_pc_q + DATA_WIDTH'(4);

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q;
    logic target_bad;
    logic rsp_pending;
    assign target_bad  = redirect && (target_raw[1:0] != 2'b00);
    assign rsp_pending = (state_q == S_WAIT) || ((state_q == S_TRAP) && stale_q);
    assign misalign    = misalign_q;
`else
    assign misalign    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            fetch_addr_q  <= '0;
            stale_q       <= 1'b0;
            req_valid_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q    <= 1'b0;
`endif
        end else begin
            if (instr_valid_q && !stall)
                instr_valid_q <= 1'b0;
            if (redirect) begin
                instr_valid_q <= 1'b0;
                pc_q          <= target;
            end

            case (state_q)
                S_REQ: begin
                    if (accept) begin
                        fetch_addr_q <= pc_q;
                        stale_q      <= redirect;
                        state_q      <= S_WAIT;
                        req_valid_q  <= 1'b0;
                        if (!redirect)
                            pc_q <= pc_q + DATA_WIDTH'(4);
                    end else begin
                        req_valid_q  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_rsp_valid) begin
                        stale_q <= 1'b0;
                        if (!redirect && !stale_q) begin
                            instr_q       <= imem.imem_rdata;
                            instr_pc_q    <= fetch_addr_q;
                            instr_valid_q <= 1'b1;
                            state_q       <= stall ? S_HOLD : S_REQ;
                            req_valid_q   <= !stall;
                        end else begin
                            state_q       <= S_REQ;
                            req_valid_q   <= 1'b1;
                        end
                    end else if (redirect) begin
                        stale_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect || !stall) begin
                        state_q     <= S_REQ;
                        req_valid_q <= 1'b1;
                    end
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                S_TRAP: begin
                    if (imem.imem_rsp_valid)
                        stale_q <= 1'b0;
                    if (redirect && !target_bad) begin
                        misalign_q <= 1'b0;
                        // A response still owed by memory must drain before refetching.
                        if (stale_q && !imem.imem_rsp_valid) begin
                            state_q     <= S_WAIT;
                        end else begin
                            state_q     <= S_REQ;
                            req_valid_q <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state_q     <= S_REQ;
                    req_valid_q <= 1'b0;
                end
            endcase

`ifdef FETCH_MISALIGN_TRAP_EN
            if (target_bad) begin
                state_q       <= S_TRAP;
                misalign_q    <= 1'b1;
                instr_pc_q    <= target;
                instr_valid_q <= 1'b0;
                req_valid_q   <= 1'b0;
                stale_q       <= accept || (rsp_pending && !imem.imem_rsp_valid);
            end
`endif
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with RESET_PC=0x100 and a latency-programmable memory model.
// Memory returns rdata = addr ^ 32'hDEAD0000; expected words are written out as constants.
module tb_fetch_sequencer;
    logic        clk;
    logic        rst_n;
    logic [1:0]  PCsrc;
    logic [31:0] br_pc;
    logic [31:0] ImmOp;
    logic [31:0] ALUresult;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pcplus4;
    logic        misalign;

    int checks;
    int errors;

    fetch_sequencer_if #(.DATA_WIDTH(32)) bus ();

    fetch_sequencer #(
        .DATA_WIDTH (32),
        .RESET_PC   (32'h0000_0100)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .PCsrc       (PCsrc),
        .br_pc       (br_pc),
        .ImmOp       (ImmOp),
        .ALUresult   (ALUresult),
        .stall       (stall),
        .imem        (bus.master),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .pcplus4     (pcplus4),
        .misalign    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: samples accepts at negedge, answers mem_lat cycles later.
    int          mem_lat;
    logic        pend;
    int          cnt;
    logic [31:0] paddr;

    initial begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rdata     = '0;
        pend               = 1'b0;
        cnt                = 0;
        paddr              = '0;
        forever begin
            @(negedge clk);
            bus.imem_rsp_valid = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rdata     = paddr ^ 32'hDEAD_0000;
                    pend               = 1'b0;
                end else begin
                    cnt = cnt - 1;
                end
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                pend  = 1'b1;
                paddr = bus.imem_addr;
                cnt   = mem_lat - 1;
            end
        end
    end

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_buf(input string tag, input logic [31:0] w, input logic [31:0] pc);
        chk({tag, "_iv"},  {31'd0, instr_valid}, 32'd1);
        chk({tag, "_ins"}, instr, w);
        chk({tag, "_ipc"}, instr_pc, pc);
        chk({tag, "_p4"},  pcplus4, pc + 32'd4);
    endtask

    task automatic chk_req(input string tag, input logic v, input logic [31:0] a);
        chk({tag, "_rv"}, {31'd0, bus.imem_req_valid}, {31'd0, v});
        if (v) chk({tag, "_addr"}, bus.imem_addr, a);
    endtask

    task automatic chk_iv0(input string tag);
        chk({tag, "_iv0"}, {31'd0, instr_valid}, 32'd0);
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; PCsrc = 2'b00; br_pc = '0; ImmOp = '0; ALUresult = '0; stall = 1'b0;
        bus.imem_req_ready = 1'b1;
        mem_lat = 1;

        nxt();
        chk_req("rst", 1'b0, 32'h0);
        chk_iv0("rst");
        chk("rst_ins", instr, 32'h0);
        chk("rst_ipc", instr_pc, 32'h0);
        chk("rst_p4", pcplus4, 32'h4);
        chk("rst_addr", bus.imem_addr, 32'h100);
        chk("rst_mis", {31'd0, misalign}, 32'd0);
        rst_n = 1'b1;

        // Sequential fetch, zero-wait memory: one instruction per two cycles
        nxt(); chk_req("A", 1'b1, 32'h100); chk_iv0("A");
        nxt(); chk_req("B", 1'b0, 32'h0);   chk_iv0("B");
        nxt(); chk_buf("C", 32'hDEAD_0100, 32'h100); chk_req("C", 1'b1, 32'h104);
        nxt(); chk_req("D", 1'b0, 32'h0);   chk_iv0("D");
        nxt(); chk_buf("E", 32'hDEAD_0104, 32'h104); chk_req("E", 1'b1, 32'h108);
        mem_lat = 2;
        nxt(); chk_req("F", 1'b0, 32'h0);
        nxt(); chk_buf("G", 32'hDEAD_0108, 32'h108); chk_req("G", 1'b1, 32'h10C);

        // Branch redirect while 0x10C is in flight: 0x200 + (-16) = 0x1F0
        nxt(); chk_req("H", 1'b0, 32'h0); chk_iv0("H");
        PCsrc = 2'b01; br_pc = 32'h200; ImmOp = 32'hFFFF_FFF0; mem_lat = 1;
        nxt(); chk_req("I", 1'b0, 32'h0); chk_iv0("I");
        PCsrc = 2'b00;
        nxt(); chk_req("J", 1'b1, 32'h1F0); chk_iv0("J");
        nxt(); chk_req("K", 1'b0, 32'h0);   chk_iv0("K");
        nxt(); chk_buf("L", 32'hDEAD_01F0, 32'h1F0); chk_req("L", 1'b1, 32'h1F4);

        // JALR coinciding with accept of 0x1F4: that response is dropped
        PCsrc = 2'b10; ALUresult = 32'h3000;
        nxt(); chk_req("M", 1'b0, 32'h0); chk_iv0("M");
        PCsrc = 2'b00;
        nxt(); chk_req("N", 1'b1, 32'h3000); chk_iv0("N");
        nxt(); chk_req("O", 1'b0, 32'h0);
        stall = 1'b1;

        // Stalled decode: buffer holds, no requests
        nxt(); chk_buf("P", 32'hDEAD_3000, 32'h3000); chk_req("P", 1'b0, 32'h0);
        nxt(); chk_buf("Q", 32'hDEAD_3000, 32'h3000); chk_req("Q", 1'b0, 32'h0);
        nxt(); chk_buf("R", 32'hDEAD_3000, 32'h3000); chk_req("R", 1'b0, 32'h0);
        stall = 1'b0;
        nxt(); chk_req("S", 1'b1, 32'h3004); chk_iv0("S");

        // PC wrap at top of address space
        PCsrc = 2'b10; ALUresult = 32'hFFFF_FFFC;
        nxt(); chk_req("T", 1'b0, 32'h0); chk_iv0("T");
        PCsrc = 2'b00;
        nxt(); chk_req("U", 1'b1, 32'hFFFF_FFFC);
        nxt(); chk_req("V", 1'b0, 32'h0);
        nxt(); chk_buf("W", 32'h2152_FFFC, 32'hFFFF_FFFC);
        chk("W_p4wrap", pcplus4, 32'h0);
        chk_req("W", 1'b1, 32'h0);

        // Misaligned JALR target 0x402
        PCsrc = 2'b10; ALUresult = 32'h402;
        nxt(); chk_req("X", 1'b0, 32'h0); chk_iv0("X");
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("X_mis", {31'd0, misalign}, 32'd1);
        chk("X_ipc", instr_pc, 32'h402);
        PCsrc = 2'b00;
        nxt(); chk_req("Y", 1'b0, 32'h0); chk_iv0("Y");
        chk("Y_mis", {31'd0, misalign}, 32'd1);
        PCsrc = 2'b10; ALUresult = 32'h400;
`else
        chk("X_mis", {31'd0, misalign}, 32'd0);
        PCsrc = 2'b00;
`endif
        nxt(); chk_req("Q0", 1'b1, 32'h400);
        chk("Q0_mis", {31'd0, misalign}, 32'd0);
        PCsrc = 2'b00;
        nxt(); chk_req("Q1", 1'b0, 32'h0);
        mem_lat = 2;
        nxt(); chk_buf("Q2", 32'hDEAD_0400, 32'h400); chk_req("Q2", 1'b1, 32'h404);

        // Reset mid-WAIT: the late response for 0x404 must be ignored
        nxt(); chk_req("Q3", 1'b0, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("arst_addr", bus.imem_addr, 32'h100);
        chk_req("arst", 1'b0, 32'h0);
        nxt(); chk_iv0("Q4");
        chk("Q4_ipc", instr_pc, 32'h0);
        chk("Q4_p4", pcplus4, 32'h4);
        rst_n = 1'b1; mem_lat = 1;
        nxt(); chk_req("Q5", 1'b1, 32'h100); chk_iv0("Q5");
        nxt(); chk_req("Q6", 1'b0, 32'h0);   chk_iv0("Q6");
        nxt(); chk_buf("Q7", 32'hDEAD_0100, 32'h100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
